// File: rtl/beat_tone_synth.sv
// Beat-triggered square-wave drum tone generator.
// Each accepted beat starts a square wave whose amplitude comes from the beat intensity.
// The amplitude halves every DECAY_TICKS samples.
// Beats arriving inside the lockout window after an accepted beat are counted and dropped.
module beat_tone_synth #(
  parameter int unsigned HALF_PERIOD = 24,
  parameter int unsigned DECAY_TICKS = 480,
  parameter int unsigned LOCKOUT     = 4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        beat_en,
  input  logic [1:0]  beat_intensity,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  output logic        busy,
  output logic [7:0]  beat_count,
  output logic [7:0]  drop_count
);

  localparam int unsigned HalfW  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned DecayW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int unsigned LockW  = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  localparam logic [HalfW-1:0]  HalfLast  = HalfW'(HALF_PERIOD - 1);
  localparam logic [DecayW-1:0] DecayLast = DecayW'(DECAY_TICKS - 1);
  localparam logic [LockW-1:0]  LockInit  = LockW'(LOCKOUT);

  typedef enum logic [0:0] {StIdle, StPlay} state_e;

  state_e             state_q, state_d;
  logic [15:0]        amp_q, amp_d;
  logic               phase_q, phase_d;
  logic [HalfW-1:0]   half_cnt_q, half_cnt_d;
  logic [DecayW-1:0]  decay_cnt_q, decay_cnt_d;
  logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [15:0]        audio_sample_q, audio_sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic               busy_q, busy_d;
  logic [7:0]         beat_count_q, beat_count_d;
  logic [7:0]         drop_count_q, drop_count_d;

  logic               beat_hit;
  logic               trigger;
  logic               reject;
  logic [15:0]        amp_start;
  logic [15:0]        amp_neg;

  // Decode the beat input and the start amplitude for an accepted beat.
  always_comb begin
    beat_hit = beat_en && (beat_intensity != 2'd0);
    trigger  = beat_hit && (lock_cnt_q == '0);
    reject   = beat_hit && (lock_cnt_q != '0);
    amp_neg  = 16'd0 - amp_q;
    case (beat_intensity)
      2'd1:    amp_start = 16'h1000;
      2'd2:    amp_start = 16'h2000;
      2'd3:    amp_start = 16'h4000;
      default: amp_start = 16'h0000;
    endcase
  end

  // Next-state logic: per-sample tone advance, then trigger loads override counters.
  always_comb begin
    state_d        = state_q;
    amp_d          = amp_q;
    phase_d        = phase_q;
    half_cnt_d     = half_cnt_q;
    decay_cnt_d    = decay_cnt_q;
    lock_cnt_d     = lock_cnt_q;
    audio_sample_d = audio_sample_q;
    sample_valid_d = 1'b0;
    beat_count_d   = beat_count_q;
    drop_count_d   = drop_count_q;

    if (sample_tick) begin
      // Sample reflects the register values from before this cycle's updates.
      sample_valid_d = 1'b1;
      if (state_q == StPlay) begin
        audio_sample_d = phase_q ? amp_neg : amp_q;
      end else begin
        audio_sample_d = 16'h0000;
      end

      if (lock_cnt_q != '0) begin
        lock_cnt_d = lock_cnt_q - LockW'(1);
      end

      if (state_q == StPlay) begin
        if (half_cnt_q == HalfLast) begin
          half_cnt_d = '0;
          phase_d    = ~phase_q;
        end else begin
          half_cnt_d = half_cnt_q + HalfW'(1);
        end

        if (decay_cnt_q == DecayLast) begin
          decay_cnt_d = '0;
          amp_d       = amp_q >> 1;
          // Tone has decayed to silence.
          if (amp_q[15:1] == 15'd0) begin
            state_d = StIdle;
            phase_d = 1'b0;
          end
        end else begin
          decay_cnt_d = decay_cnt_q + DecayW'(1);
        end
      end
    end

    if (trigger) begin
      state_d      = StPlay;
      amp_d        = amp_start;
      phase_d      = 1'b0;
      half_cnt_d   = '0;
      decay_cnt_d  = '0;
      lock_cnt_d   = LockInit;
      beat_count_d = beat_count_q + 8'd1;
    end

    if (reject && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end

    busy_d = (state_d == StPlay);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      amp_q          <= 16'h0000;
      phase_q        <= 1'b0;
      half_cnt_q     <= '0;
      decay_cnt_q    <= '0;
      lock_cnt_q     <= '0;
      audio_sample_q <= 16'h0000;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      beat_count_q   <= 8'd0;
      drop_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      amp_q          <= amp_d;
      phase_q        <= phase_d;
      half_cnt_q     <= half_cnt_d;
      decay_cnt_q    <= decay_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      audio_sample_q <= audio_sample_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      beat_count_q   <= beat_count_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign audio_sample = audio_sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign beat_count   = beat_count_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_beat_tone_synth.sv
// Self-checking bench for beat_tone_synth using a tone-level reference model.
module tb_beat_tone_synth;

  localparam int unsigned HP = 4;
  localparam int unsigned DT = 8;
  localparam int unsigned LK = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        beat_en = 1'b0;
  logic [1:0]  beat_intensity = 2'd0;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        busy;
  logic [7:0]  beat_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  beat_tone_synth #(
    .HALF_PERIOD (HP),
    .DECAY_TICKS (DT),
    .LOCKOUT     (LK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_tick    (sample_tick),
    .beat_en        (beat_en),
    .beat_intensity (beat_intensity),
    .audio_sample   (audio_sample),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .beat_count     (beat_count),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // Free-running sample strobe, one clk in four, unless the stimulus takes it over.
  int clk_div = 0;
  bit tick_en = 1'b1;
  always @(negedge clk) begin
    clk_div++;
    if (tick_en) sample_tick = ((clk_div % 4) == 0);
  end

  // Reference model: a tone is (start level, samples since trigger); the level after n
  // samples is start >> (n / DT) and the sign flips every HP samples.
  bit          m_play = 1'b0;
  int          m_a0 = 0;
  int          m_n = 0;
  int          m_lock = 0;
  int          m_beats = 0;
  int          m_drops = 0;
  logic [15:0] e_sample = 16'h0;
  logic        e_valid = 1'b0;
  logic        e_busy = 1'b0;
  int          m_lvl;
  bit          m_trig;
  bit          m_rej;

  function automatic int start_level(input logic [1:0] i);
    case (i)
      2'd1:    return 4096;
      2'd2:    return 8192;
      2'd3:    return 16384;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play = 1'b0; m_a0 = 0; m_n = 0; m_lock = 0; m_beats = 0; m_drops = 0;
      e_sample = 16'h0; e_valid = 1'b0; e_busy = 1'b0;
    end else begin
      m_trig  = beat_en && (beat_intensity != 2'd0) && (m_lock == 0);
      m_rej   = beat_en && (beat_intensity != 2'd0) && (m_lock != 0);
      e_valid = sample_tick;
      if (sample_tick) begin
        if (m_play) begin
          m_lvl    = m_a0 >> (m_n / DT);
          e_sample = ((m_n / HP) % 2 == 1) ? 16'(-m_lvl) : 16'(m_lvl);
          m_n++;
          if ((m_a0 >> (m_n / DT)) == 0) m_play = 1'b0;
        end else begin
          e_sample = 16'h0;
        end
        if (m_lock > 0) m_lock--;
      end
      if (m_trig) begin
        m_play  = 1'b1;
        m_a0    = start_level(beat_intensity);
        m_n     = 0;
        m_lock  = LK;
        m_beats = (m_beats + 1) % 256;
      end
      if (m_rej && m_drops < 255) m_drops++;
      e_busy = m_play;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (audio_sample !== e_sample || sample_valid !== e_valid || busy !== e_busy ||
          beat_count !== 8'(m_beats) || drop_count !== 8'(m_drops)) begin
        failures++;
        $display("FAIL model t=%0t sample=%h/%h valid=%b/%b busy=%b/%b beats=%0d/%0d drops=%0d/%0d",
                 $time, audio_sample, e_sample, sample_valid, e_valid, busy, e_busy,
                 beat_count, m_beats, drop_count, m_drops);
      end
    end
  end

  // Every emitted sample, for literal spot checks.
  logic [15:0] caps[$];
  always @(negedge clk) begin
    if (!rst && sample_valid) caps.push_back(audio_sample);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_cap(input string name, input int idx, input logic [15:0] exp);
    checks++;
    if (caps.size() <= idx) begin
      failures++;
      $display("FAIL %s missing sample %0d (have %0d) expected=%h", name, idx, caps.size(), exp);
    end else if (caps[idx] !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, caps[idx], exp);
    end
  endtask

  task automatic drive_point();
    @(negedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    repeat (4 * n) drive_point();
  endtask

  task automatic beat(input logic [1:0] i);
    drive_point();
    beat_en = 1'b1;
    beat_intensity = i;
    drive_point();
    beat_en = 1'b0;
    beat_intensity = 2'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 5000) begin
      drive_point();
      k++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  int nonzero;

  initial begin
    // 1. Reset and idle samples, then asynchronous reset mid-tone.
    repeat (3) drive_point();
    rst = 1'b0;
    caps.delete();
    run_ticks(10);
    nonzero = 0;
    foreach (caps[i]) if (caps[i] != 16'h0) nonzero++;
    chk("idle_sample_count", 32'(caps.size() >= 9), 32'd1);
    chk("idle_samples_zero", 32'(nonzero), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    beat(2'd1);
    run_ticks(6);
    chk("midtone_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_sample", 32'(audio_sample), 32'h0);
    chk("rst_async_valid", 32'(sample_valid), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_beats", 32'(beat_count), 32'd0);
    chk("rst_async_drops", 32'(drop_count), 32'd0);
    drive_point();
    drive_point();
    rst = 1'b0;

    // 2. Single beat, intensity 1, full decay.
    beat(2'd1);
    caps.delete();
    run_ticks(110);
    chk_cap("tone1_s0", 0, 16'h1000);
    chk_cap("tone1_s3", 3, 16'h1000);
    chk_cap("tone1_s4", 4, 16'hF000);
    chk_cap("tone1_s8", 8, 16'h0800);
    chk_cap("tone1_s12", 12, 16'hF800);
    chk_cap("tone1_s96", 96, 16'h0001);
    chk_cap("tone1_s100", 100, 16'hFFFF);
    chk_cap("tone1_s104", 104, 16'h0000);
    chk("tone1_busy_end", 32'(busy), 32'd0);
    chk("tone1_beats", 32'(beat_count), 32'd1);

    // 3. Intensity mapping and ignored intensity 0.
    wait_idle();
    beat(2'd2);
    caps.delete();
    run_ticks(2);
    chk_cap("int2_first", 0, 16'h2000);
    wait_idle();
    beat(2'd3);
    caps.delete();
    run_ticks(2);
    chk_cap("int3_first", 0, 16'h4000);
    wait_idle();
    beat(2'd0);
    run_ticks(3);
    chk("int0_busy", 32'(busy), 32'd0);
    chk("int0_beats", 32'(beat_count), 32'd3);
    chk("int0_drops", 32'(drop_count), 32'd0);

    // 4. Lockout rejection, then retrigger after the window.
    beat(2'd1);
    caps.delete();
    run_ticks(5);
    beat(2'd1);
    chk("lock_drop", 32'(drop_count), 32'd1);
    chk("lock_beats", 32'(beat_count), 32'd4);
    run_ticks(12);
    chk_cap("lock_tone_s4", 4, 16'hF000);
    chk_cap("lock_tone_s8", 8, 16'h0800);
    beat(2'd3);
    caps.delete();
    run_ticks(1);
    chk_cap("retrig_first", 0, 16'h4000);
    chk("retrig_beats", 32'(beat_count), 32'd5);

    // 5. Beat coincident with a sample strobe while idle.
    wait_idle();
    run_ticks(20);
    tick_en = 1'b0;
    sample_tick = 1'b0;
    drive_point();
    caps.delete();
    chk("coinc_busy_before", 32'(busy), 32'd0);
    sample_tick = 1'b1;
    beat_en = 1'b1;
    beat_intensity = 2'd2;
    drive_point();
    sample_tick = 1'b0;
    beat_en = 1'b0;
    beat_intensity = 2'd0;
    chk("coinc_busy_after", 32'(busy), 32'd1);
    chk_cap("coinc_sample0", 0, 16'h0000);
    drive_point();
    drive_point();
    sample_tick = 1'b1;
    drive_point();
    sample_tick = 1'b0;
    chk_cap("coinc_sample1", 1, 16'h2000);
    tick_en = 1'b1;

    // 6. Beat counter wrap and drop counter saturation.
    rst = 1'b1;
    drive_point();
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      beat(2'd1);
      run_ticks(18);
    end
    chk("wrap_beats", 32'(beat_count), 32'd44);
    tick_en = 1'b0;
    sample_tick = 1'b0;
    for (int i = 0; i < 301; i++) beat(2'd1);
    chk("sat_beats", 32'(beat_count), 32'd45);
    chk("sat_drops", 32'(drop_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
